// File: rtl/instr_mem_pkg.sv
// Shared types and helpers for the loadable instruction memory.
// Optional build macro: PARITY_EN (used by instr_mem_loadable).
package instr_mem_pkg;

  // Two-state controller: stream program words in, then serve fetches.
  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } state_e;

  // HALT opcode placed in the top five bits of the fault word.
  localparam logic [4:0] HALT_OP = 5'd18;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 10;
  localparam int DEF_DEPTH  = 141;

  // A fetch faults when the address has bits above the pointer width,
  // lies beyond the physical depth, or lies beyond the loaded program.
  function automatic logic fetch_faults(input logic [31:0] addr,
                                        input logic [31:0] count,
                                        input int          depth,
                                        input int          addr_w);
    logic        f;
    logic [31:0] d32;
    f   = 1'b0;
    d32 = 32'(depth);
    if ((addr >> addr_w) != 32'd0) f = 1'b1;
    if (addr >= d32)               f = 1'b1;
    if (addr >= count)             f = 1'b1;
    return f;
  endfunction

endpackage

// File: rtl/instr_mem_array.sv
// DEPTH x MEM_W single-write, single-read synchronous RAM.
// The read register holds its value when no read is requested, and is the
// only part cleared by reset; stored words are never reset.
module instr_mem_array #(
  parameter int MEM_W = 32,
  parameter int DEPTH = 141,
  parameter int IDX_W = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_addr,
  input  logic [MEM_W-1:0] wr_data,
  input  logic             rd_en,
  input  logic [IDX_W-1:0] rd_addr,
  output logic [MEM_W-1:0] rd_data
);

  logic [MEM_W-1:0] mem_q [DEPTH];
  logic [MEM_W-1:0] rd_data_q;
  logic [MEM_W-1:0] rd_data_d;

  // Storage write port; the caller never writes beyond DEPTH-1.
  always_ff @(posedge clock) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  // Read mux: capture a new word only on a read, otherwise hold.
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) rd_data_d = mem_q[rd_addr];
  end

  // Read register with asynchronous clear.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) rd_data_q <= '0;
    else          rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/instr_mem_loadable.sv
// Loadable instruction memory: program words stream in over a valid/ready
// load port after reset, then the block serves range-checked fetches with
// one-cycle latency. Optional build macro: PARITY_EN adds a stored even
// parity bit per word and a parity_err output.
//
// Handshakes: a load word transfers on a rising edge where load_valid and
// load_ready are both high; a fetch transfers on a rising edge where
// fetch_req and fetch_ready are both high. Ready depends only on state, never
// on the valid/req inputs. Each accepted fetch yields exactly one
// instr_valid cycle on the following clock.
module instr_mem_loadable
  import instr_mem_pkg::*;
#(
  parameter int                 DATA_W    = DEF_DATA_W,
  parameter int                 ADDR_W    = DEF_ADDR_W,
  parameter int                 DEPTH     = DEF_DEPTH,
  parameter logic [DATA_W-1:0]  HALT_WORD = {HALT_OP, {(DATA_W-5){1'b0}}}
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  input  logic              reload,
  input  logic              fetch_req,
  output logic              fetch_ready,
  input  logic [31:0]       fetch_addr,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  output logic              addr_fault,
  output logic [ADDR_W:0]   loaded_count,
  output logic              run
`ifdef PARITY_EN
  ,
  output logic              parity_err
`endif
);

  localparam int CNT_W = ADDR_W + 1;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   loaded_count_q, loaded_count_d;
  logic               instr_valid_q, instr_valid_d;
  logic               fault_q, fault_d;

  logic               load_accept;
  logic               fetch_accept;
  logic               range_fault;
  logic [MEM_W-1:0]   wr_word;
  logic [MEM_W-1:0]   rd_word;

  assign load_accept  = load_valid & (state_q == LOAD);
  assign fetch_accept = fetch_req & (state_q == RUN);
  assign range_fault  = fetch_faults(fetch_addr, 32'(loaded_count_q), DEPTH, ADDR_W);

`ifdef PARITY_EN
  // Stored bit makes the whole word even parity.
  assign wr_word = {^load_data, load_data};
`else
  assign wr_word = load_data;
`endif

  // The write pointer is the loaded-word count; a faulted fetch skips the
  // array read so an out-of-range address never indexes storage.
  instr_mem_array #(
    .MEM_W (MEM_W),
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .clock   (clock),
    .reset_n (reset_n),
    .wr_en   (load_accept),
    .wr_addr (loaded_count_q[IDX_W-1:0]),
    .wr_data (wr_word),
    .rd_en   (fetch_accept & ~range_fault),
    .rd_addr (fetch_addr[IDX_W-1:0]),
    .rd_data (rd_word)
  );

  // Next-state, load pointer and state-derived handshake outputs.
  always_comb begin
    state_d        = state_q;
    loaded_count_d = loaded_count_q;
    load_ready     = 1'b0;
    fetch_ready    = 1'b0;
    run            = 1'b0;
    case (state_q)
      LOAD: begin
        load_ready = 1'b1;
        if (load_accept) begin
          loaded_count_d = loaded_count_q + CNT_W'(1);
          if (load_last || (loaded_count_q == CNT_W'(DEPTH - 1))) state_d = RUN;
        end
      end
      RUN: begin
        fetch_ready = 1'b1;
        run         = 1'b1;
        // A fetch presented alongside reload is still accepted this cycle.
        if (reload) begin
          state_d        = LOAD;
          loaded_count_d = '0;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  // Fetch pipeline: valid pulses once per accept; fault flag holds with instr.
  always_comb begin
    instr_valid_d = fetch_accept;
    fault_d       = fault_q;
    if (fetch_accept) fault_d = range_fault;
  end

  // Controller and fetch-pipeline registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= LOAD;
      loaded_count_q <= '0;
      instr_valid_q  <= 1'b0;
      fault_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      loaded_count_q <= loaded_count_d;
      instr_valid_q  <= instr_valid_d;
      fault_q        <= fault_d;
    end
  end

`ifdef PARITY_EN
  logic par_bad;
  // A nonzero XOR over data plus parity means the stored word was corrupted.
  assign par_bad    = ^rd_word;
  assign instr      = (fault_q | par_bad) ? HALT_WORD : rd_word[DATA_W-1:0];
  assign parity_err = instr_valid_q & ~fault_q & par_bad;
`else
  assign instr      = fault_q ? HALT_WORD : rd_word;
`endif

  assign instr_valid  = instr_valid_q;
  assign addr_fault   = fault_q;
  assign loaded_count = loaded_count_q;

endmodule

// File: tb/tb_instr_mem_loadable.sv
// Testbench for instr_mem_loadable: randomized loads and fetches checked
// against a program-array model through an expected-response queue.
module tb_instr_mem_loadable;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 10;
  localparam int DEPTH  = 141;
  localparam logic [31:0] HALT = 32'h9000_0000;

  logic              clock;
  logic              reset_n;
  logic              load_valid;
  logic              load_ready;
  logic [DATA_W-1:0] load_data;
  logic              load_last;
  logic              reload;
  logic              fetch_req;
  logic              fetch_ready;
  logic [31:0]       fetch_addr;
  logic [DATA_W-1:0] instr;
  logic              instr_valid;
  logic              addr_fault;
  logic [ADDR_W:0]   loaded_count;
  logic              run;
`ifdef PARITY_EN
  logic              parity_err;
`endif

  int errors = 0;
  int checks = 0;

  // Expected fetch responses: {addr_fault, instr}
  logic [DATA_W:0] exp_q[$];

  // Reference model: program as an array plus number of words loaded
  logic [DATA_W-1:0] ref_mem [DEPTH];
  int                ref_count = 0;

  instr_mem_loadable dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .load_valid   (load_valid),
    .load_ready   (load_ready),
    .load_data    (load_data),
    .load_last    (load_last),
    .reload       (reload),
    .fetch_req    (fetch_req),
    .fetch_ready  (fetch_ready),
    .fetch_addr   (fetch_addr),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .addr_fault   (addr_fault),
    .loaded_count (loaded_count),
    .run          (run)
`ifdef PARITY_EN
    ,
    .parity_err   (parity_err)
`endif
  );

  // Clock and watchdog
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Fetch outcome straight from the rules: in range of both the depth and
  // the loaded program returns the stored word, anything else is HALT.
  function automatic logic [DATA_W:0] model_fetch(input logic [31:0] a);
    if (a >= 32'(DEPTH) || a >= 32'(ref_count)) return {1'b1, HALT};
    return {1'b0, ref_mem[int'(a)]};
  endfunction

  // Driver: offer one load word, waiting a bounded time for load_ready.
  task automatic load_word(input logic [DATA_W-1:0] d, input logic last);
    int budget;
    budget     = 0;
    load_valid = 1'b1;
    load_data  = d;
    load_last  = last;
    while (!load_ready && budget < 20) begin
      @(posedge clock); #1;
      budget++;
    end
    if (!load_ready) begin
      checks++;
      errors++;
      $display("FAIL load_timeout: got load_ready=0 want 1");
    end else begin
      if (ref_count < DEPTH) ref_mem[ref_count] = d;
      ref_count++;
      @(posedge clock); #1;
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  // Driver: one-cycle fetch request; expectation queued only if accepted.
  task automatic do_fetch(input logic [31:0] a);
    fetch_req  = 1'b1;
    fetch_addr = a;
    if (fetch_ready) exp_q.push_back(model_fetch(a));
    @(posedge clock); #1;
    fetch_req = 1'b0;
  endtask

  // Monitor / scoreboard: every instr_valid cycle consumes one expectation.
  always @(negedge clock) begin
    if (reset_n && instr_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_instr_valid: got instr=%0h with empty queue", instr);
      end else begin
        logic [DATA_W:0] e;
        e = exp_q.pop_front();
        check("fetch_instr", 64'(instr), 64'(e[DATA_W-1:0]));
        check("fetch_fault", 64'(addr_fault), 64'(e[DATA_W]));
`ifdef PARITY_EN
        check("parity_err", 64'(parity_err), 64'd0);
`endif
      end
    end
  end

  initial begin
    reset_n    = 1'b1;
    load_valid = 1'b0;
    load_data  = '0;
    load_last  = 1'b0;
    reload     = 1'b0;
    fetch_req  = 1'b0;
    fetch_addr = '0;
    #3 reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_instr", 64'(instr), 64'd0);
    check("rst_instr_valid", 64'(instr_valid), 64'd0);
    check("rst_addr_fault", 64'(addr_fault), 64'd0);
    check("rst_run", 64'(run), 64'd0);
    check("rst_loaded_count", 64'(loaded_count), 64'd0);
    check("rst_load_ready", 64'(load_ready), 64'd1);
    check("rst_fetch_ready", 64'(fetch_ready), 64'd0);
    reset_n = 1'b1;
    @(posedge clock); #1;

    // Short program with load_last on the third word
    load_word(32'hC840_0000, 1'b0);
    load_word(32'hC040_0014, 1'b0);
    check("pre_last_run", 64'(run), 64'd0);
    load_word(HALT, 1'b1);
    check("short_run", 64'(run), 64'd1);
    check("short_count", 64'(loaded_count), 64'd3);
    check("short_load_ready", 64'(load_ready), 64'd0);
    do_fetch(32'd0);
    do_fetch(32'd1);
    do_fetch(32'd2);
    do_fetch(32'd3);
    do_fetch(32'h0000_0400);
    for (int i = 0; i < 20; i++) begin
      if ($urandom_range(0, 3) == 0) do_fetch($urandom());
      else do_fetch(32'($urandom_range(0, 6)));
    end
    @(posedge clock); #1;

    // Reload, then fill the whole array without load_last
    reload = 1'b1;
    @(posedge clock); #1;
    reload    = 1'b0;
    ref_count = 0;
    check("reload_run", 64'(run), 64'd0);
    for (int i = 0; i < DEPTH; i++) begin
      if (i == DEPTH - 1) check("full_ready_last", 64'(load_ready), 64'd1);
      load_word($urandom(), 1'b0);
    end
    check("full_run", 64'(run), 64'd1);
    check("full_load_ready", 64'(load_ready), 64'd0);
    check("full_count", 64'(loaded_count), 64'(DEPTH));
    do_fetch(32'(DEPTH - 1));
    do_fetch(32'(DEPTH));
    for (int i = 0; i < 30; i++) do_fetch(32'($urandom_range(0, DEPTH + 8)));

    // Reload together with a fetch: fetch completes, then back in LOAD
    reload     = 1'b1;
    fetch_req  = 1'b1;
    fetch_addr = 32'd1;
    check("reload_fetch_ready", 64'(fetch_ready), 64'd1);
    if (fetch_ready) exp_q.push_back(model_fetch(32'd1));
    @(posedge clock); #1;
    reload    = 1'b0;
    fetch_req = 1'b0;
    ref_count = 0;
    check("after_reload_run", 64'(run), 64'd0);
    check("after_reload_count", 64'(loaded_count), 64'd0);
    check("after_reload_fetch_ready", 64'(fetch_ready), 64'd0);
    do_fetch(32'd0);  // refused while loading: nothing may come back
    load_word(32'h1234_5678, 1'b0);
    load_word(32'hABCD_0001, 1'b1);
    do_fetch(32'd1);
    do_fetch(32'd0);
    do_fetch(32'd2);
    @(posedge clock); #1;

    // Reset in the middle of a load
    reload = 1'b1;
    @(posedge clock); #1;
    reload    = 1'b0;
    ref_count = 0;
    for (int i = 0; i < 5; i++) load_word($urandom(), 1'b0);
    check("mid_load_count", 64'(loaded_count), 64'd5);
    reset_n = 1'b0;
    #1;
    ref_count = 0;
    check("midrst_instr_valid", 64'(instr_valid), 64'd0);
    check("midrst_count", 64'(loaded_count), 64'd0);
    check("midrst_load_ready", 64'(load_ready), 64'd1);
    @(posedge clock); #1;
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) load_word($urandom(), i == 9);
    check("reload10_count", 64'(loaded_count), 64'd10);
    check("reload10_run", 64'(run), 64'd1);
    for (int i = 0; i <= 10; i++) do_fetch(32'(i));
    for (int i = 0; i < 15; i++) do_fetch(32'($urandom_range(0, 20)));

    repeat (3) @(posedge clock);
    #1;
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
